// File: rtl/viterbi_pkg.sv
// Shared Viterbi trellis helpers: state count, predecessor mapping and the
// survivor-path FSM encoding.
package viterbi_pkg;

    localparam int unsigned K_DEF = 3;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sp_state_e;

    typedef logic [K_DEF-2:0] state_idx_t;

    function automatic int unsigned ns(input int unsigned k);
        return 32'(1) << (k - 1);
    endfunction

    // Lower predecessor of state s; the upper one is this plus one.
    function automatic int unsigned pred0(input int unsigned s, input int unsigned n);
        return 2 * (s % (n / 2));
    endfunction

endpackage

// File: rtl/survivor_path_re_sp_row.sv
// One survivor row: shifts in the state's input bit behind the chosen
// predecessor's history, with synchronous clear taking priority.
module sp_row #(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_sel,
    input  logic [DEPTH-2:0] i_p0,
    input  logic [DEPTH-2:0] i_p1,
    input  logic             i_in_bit,
    output logic [DEPTH-1:0] o_row,
    output logic [DEPTH-1:0] o_row_next_c
);
    logic [DEPTH-1:0] r_row;
    logic [DEPTH-2:0] w_pred;

    always_comb begin
        w_pred       = i_sel ? i_p1 : i_p0;
        o_row_next_c = i_en ? {w_pred, i_in_bit} : r_row;
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_row <= '0;
        end else if (i_en) begin
            r_row <= {w_pred, i_in_bit};
        end
    end

    assign o_row = r_row;

endmodule

// File: rtl/survivor_path_re.sv
// Register-exchange survivor memory: per-state survivor rows, fill/run
// counter and an end-of-frame flush that drains the best path's tail bits.
module survivor_path_re
    import viterbi_pkg::*;
#(
    parameter int unsigned K     = 3,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [ns(K)-1:0] dec,
    input  logic [K-2:0]     best_state,
    input  logic             flush,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy
);
    localparam int unsigned NS = ns(K);
    localparam int unsigned SW = K - 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] REM_FULL = CW'(DEPTH - 1);

    sp_state_e        r_state;
    sp_state_e        w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [DEPTH-1:0] r_fsr;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_bit_last;
    logic             r_busy;

    logic             w_accept;
    logic [CW-1:0]    w_cnt_acc;
    logic [CW-1:0]    w_rem;
    logic [IW-1:0]    w_rem_i;
    logic [CW-1:0]    w_cnt_nx;
    logic [IW-1:0]    w_idx_nx;
    logic [DEPTH-1:0] w_fsr_nx;
    logic [DEPTH-1:0] w_best_nx;
    logic             w_out_nx;
    logic             w_valid_nx;
    logic             w_last_nx;
    logic             w_clr;
    logic             w_clr_all;

    logic [DEPTH-1:0] w_row    [NS];
    logic [DEPTH-1:0] w_row_nx [NS];

    assign w_accept  = dec_valid && (r_state != FLUSH);
    assign w_cnt_acc = (w_accept && (r_cnt != CNT_FULL)) ? r_cnt + CW'(1) : r_cnt;
    assign w_rem     = (w_cnt_acc == CNT_FULL) ? REM_FULL : w_cnt_acc;
    assign w_rem_i   = IW'(w_rem);
    assign w_best_nx = w_row_nx[best_state];
    assign w_clr_all = reset || w_clr;

    for (genvar s = 0; s < NS; s++) begin : g_row
        localparam int unsigned   P0    = pred0(s, NS);
        localparam logic [SW-1:0] S_IDX = SW'(s);

        sp_row #(.DEPTH(DEPTH)) u_row (
            .clk          (clk),
            .i_clr        (w_clr_all),
            .i_en         (w_accept),
            .i_sel        (dec[s]),
            .i_p0         (w_row[P0][DEPTH-2:0]),
            .i_p1         (w_row[P0+1][DEPTH-2:0]),
            .i_in_bit     (S_IDX[SW-1]),
            .o_row        (w_row[s]),
            .o_row_next_c (w_row_nx[s])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            FILL, RUN: begin
                if (flush) begin
                    w_state_nx = (w_rem == '0) ? FILL : FLUSH;
                end else if (w_cnt_acc == CNT_FULL) begin
                    w_state_nx = RUN;
                end
            end
            FLUSH: begin
                if (r_idx == '0) begin
                    w_state_nx = FILL;
                end
            end
            default: w_state_nx = FILL;
        endcase
    end

    // Next values for the registered outputs and the flush datapath.
    always_comb begin
        w_valid_nx = 1'b0;
        w_out_nx   = 1'b0;
        w_last_nx  = 1'b0;
        w_cnt_nx   = w_cnt_acc;
        w_idx_nx   = r_idx;
        w_fsr_nx   = r_fsr;
        w_clr      = 1'b0;
        case (r_state)
            FILL, RUN: begin
                if (w_accept && (w_cnt_acc == CNT_FULL)) begin
                    w_valid_nx = 1'b1;
                    w_out_nx   = w_best_nx[DEPTH-1];
                end
                if (flush) begin
                    w_fsr_nx = w_best_nx;
                    if (w_rem == '0) begin
                        w_cnt_nx = '0;
                        w_clr    = 1'b1;
                    end else begin
                        w_idx_nx = w_rem_i - IW'(1);
                    end
                end
            end
            FLUSH: begin
                w_valid_nx = 1'b1;
                w_out_nx   = r_fsr[r_idx];
                w_last_nx  = (r_idx == '0);
                w_idx_nx   = r_idx - IW'(1);
                if (r_idx == '0) begin
                    w_idx_nx = '0;
                    w_cnt_nx = '0;
                    w_clr    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_fsr       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_fsr       <= w_fsr_nx;
            r_bit_out   <= w_out_nx;
            r_bit_valid <= w_valid_nx;
            r_bit_last  <= w_last_nx;
            r_busy      <= (w_state_nx == FLUSH);
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_last  = r_bit_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_survivor_path_re.sv
// Bench for survivor_path_re (K=3, DEPTH=4): table-driven scenarios plus
// hand sequences, checked by a behavioural model feeding a timed scoreboard.
module tb_survivor_path_re;
    import viterbi_pkg::*;

    localparam int unsigned K     = 3;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dec_valid = 1'b0;
    logic [3:0] dec = '0;
    state_idx_t best_state = '0;
    logic       flush = 1'b0;
    logic       bit_out, bit_valid, bit_last, busy;

    survivor_path_re #(.K(K), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec        (dec),
        .best_state (best_state),
        .flush      (flush),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_last   (bit_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

    typedef struct {
        logic [3:0] dec;
        state_idx_t best_a;
        state_idx_t best_b;
        int         n_acc;
        int         fl_mode;   // 0 none, 1 flush after accepts, 2 flush on last accept
        logic       drain_dv;
        int         exp_bits;
        int         exp_ones;
    } vec_t;

    exp_t q[$];
    vec_t vt[9];

    logic [3:0] m_sp[4];
    int         m_cnt = 0;
    int         m_busy = 0;
    bit         m_rst_last = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    int         n_bits = 0;
    int         n_ones = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 4; s++) m_sp[s] = '0;
        m_cnt = 0;
    endtask

    // Drive one cycle and advance the reference model past that clock edge.
    task automatic step(input logic rst, input logic dv, input logic [3:0] d,
                        input state_idx_t b, input logic fl);
        logic [3:0] nsp[4];
        logic [3:0] fsr;
        int p, rem;
        @(negedge clk);
        reset = rst; dec_valid = dv; dec = d; best_state = b; flush = fl;
        @(posedge clk);
        cyc++;
        m_rst_last = rst;
        if (rst) begin
            m_clear();
            m_busy = 0;
            q.delete();
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_clear();
        end else begin
            if (dv) begin
                for (int s = 0; s < 4; s++) begin
                    p = 2 * (s % 2) + (d[s] ? 1 : 0);
                    nsp[s] = {m_sp[p][2:0], 1'(s / 2)};
                end
                for (int s = 0; s < 4; s++) m_sp[s] = nsp[s];
                if (m_cnt < 4) m_cnt++;
                if (m_cnt == 4) q.push_back('{m_sp[b][3], 1'b0, cyc});
            end
            if (fl) begin
                rem = (m_cnt == 4) ? 3 : m_cnt;
                fsr = m_sp[b];
                for (int j = 0; j < rem; j++)
                    q.push_back('{fsr[rem-1-j], (j == rem - 1), cyc + 1 + j});
                m_busy = rem;
                if (rem == 0) m_clear();
            end
        end
    endtask

    always @(negedge clk) begin : mon
        logic ev;
        exp_t e;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("bit_dropped", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            ev = (q.size() > 0) && (q[0].cyc == cyc);
            chk("bit_valid", int'(bit_valid), int'(ev));
            chk("busy", int'(busy), int'(m_busy > 0));
            n_bits += int'(bit_valid);
            n_ones += int'(bit_valid && bit_out);
            if (ev) begin
                e = q.pop_front();
                if (bit_valid) begin
                    chk("bit_out", int'(bit_out), int'(e.b));
                    chk("bit_last", int'(bit_last), int'(e.last));
                end
            end else begin
                chk("bit_last_idle", int'(bit_last), 0);
            end
            if (m_rst_last) chk("bit_out_after_reset", int'(bit_out), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'hF, 2'd3, 2'd3, 8,  0, 1'b0, 5,  5};
        vt[1] = '{4'hF, 2'd1, 2'd1, 8,  0, 1'b0, 5,  5};
        vt[2] = '{4'h0, 2'd2, 2'd0, 8,  0, 1'b0, 5,  0};
        vt[3] = '{4'hF, 2'd3, 2'd3, 10, 1, 1'b1, 10, 10};
        vt[4] = '{4'h0, 2'd2, 2'd2, 2,  1, 1'b0, 2,  1};
        vt[5] = '{4'hF, 2'd3, 2'd3, 0,  1, 1'b0, 0,  0};
        vt[6] = '{4'hF, 2'd3, 2'd3, 2,  2, 1'b0, 2,  2};
        vt[7] = '{4'hF, 2'd3, 2'd3, 5,  2, 1'b1, 5,  5};
        vt[8] = '{4'h0, 2'd2, 2'd2, 3,  1, 1'b1, 3,  1};

        m_clear();
        step(1'b1, 1'b0, 4'h0, 2'd0, 1'b0);
        mon_en = 1;

        for (int r = 0; r < 9; r++) begin
            step(1'b1, 1'b0, 4'h0, 2'd0, 1'b0);
            n_bits = 0;
            n_ones = 0;
            for (int a = 0; a < vt[r].n_acc; a++)
                step(1'b0, 1'b1, vt[r].dec, (a >= 4) ? vt[r].best_b : vt[r].best_a,
                     (vt[r].fl_mode == 2) && (a == vt[r].n_acc - 1));
            if (vt[r].fl_mode == 1)
                step(1'b0, 1'b0, vt[r].dec, vt[r].best_a, 1'b1);
            for (int i = 0; i < 8; i++)
                step(1'b0, vt[r].drain_dv && (m_busy > 0), 4'h5, vt[r].best_a,
                     vt[r].drain_dv && (m_busy > 0));
            chk($sformatf("row%0d_bits", r), n_bits, vt[r].exp_bits);
            chk($sformatf("row%0d_ones", r), n_ones, vt[r].exp_ones);
        end

        // Reset in the middle of RUN, then a fresh fill.
        step(1'b1, 1'b0, 4'h0, 2'd0, 1'b0);
        for (int a = 0; a < 6; a++) step(1'b0, 1'b1, 4'hF, 2'd3, 1'b0);
        step(1'b1, 1'b1, 4'hF, 2'd3, 1'b0);
        n_bits = 0;
        for (int a = 0; a < 3; a++) step(1'b0, 1'b1, 4'hF, 2'd3, 1'b0);
        step(1'b0, 1'b0, 4'h0, 2'd3, 1'b0);
        chk("refill_no_early_bit", n_bits, 0);
        step(1'b0, 1'b1, 4'hF, 2'd3, 1'b0);
        step(1'b0, 1'b0, 4'h0, 2'd3, 1'b0);
        step(1'b0, 1'b0, 4'h0, 2'd3, 1'b0);
        chk("refill_first_bit", n_bits, 1);

        // Reset while flushing: the remaining tail bits are dropped.
        step(1'b1, 1'b0, 4'h0, 2'd0, 1'b0);
        for (int a = 0; a < 3; a++) step(1'b0, 1'b1, 4'hF, 2'd3, 1'b0);
        step(1'b0, 1'b0, 4'h0, 2'd3, 1'b1);
        step(1'b0, 1'b0, 4'h0, 2'd3, 1'b0);
        step(1'b1, 1'b0, 4'h0, 2'd0, 1'b0);
        n_bits = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 2'd0, 1'b0);
        chk("no_bits_after_reset", n_bits, 0);

        // Mixed traffic to exercise ordering with varied survivor contents.
        for (int i = 0; i < 120; i++)
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, 2'd0, 1'b0);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
